// File: rtl/trg_sci_pkt_reader.sv
// trg_sci_pkt_reader
// Pops bytes from the trigger science-data FIFO (standard read: data valid the
// cycle after the read strobe). It hunts for the 0xEB90 sync word, collects a
// 20-byte packet, checks the CRC-16/CCITT (init 0xFFFF) and the reserved bytes,
// then presents the decoded fields on a valid/ready handshake.
// Ports:
//   clk_in, rst_in            clock, async active-high reset
//   fifo_empty_in, fifo_data_in, fifo_rd_out   FIFO read side
//   pkt_vld_out, pkt_rdy_in   downstream handshake
//   logic_grp_sel_out, hit_sig_stus_out, eff_trg_cnt_out, trg_busy_time_out
//                             decoded fields, updated only when a packet is presented
//   pkt_ok_cnt_out (wraps), crc_err_cnt_out, fmt_err_cnt_out,
//   sync_drop_cnt_out, timeout_cnt_out (saturating)   housekeeping counters
module trg_sci_pkt_reader #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        fifo_empty_in,
    input  logic [7:0]  fifo_data_in,
    output logic        fifo_rd_out,
    output logic        pkt_vld_out,
    input  logic        pkt_rdy_in,
    output logic [15:0] logic_grp_sel_out,
    output logic [15:0] hit_sig_stus_out,
    output logic [15:0] eff_trg_cnt_out,
    output logic [23:0] trg_busy_time_out,
    output logic [15:0] pkt_ok_cnt_out,
    output logic [7:0]  crc_err_cnt_out,
    output logic [7:0]  fmt_err_cnt_out,
    output logic [7:0]  sync_drop_cnt_out,
    output logic [7:0]  timeout_cnt_out
);

    typedef enum logic [1:0] {HUNT, COLLECT, CHECK, OUT} state_t;

    state_t      state, state_nxt;
    logic        run;        // holds reads off until the first edge after reset
    logic        byte_vld;
    logic        have_eb;    // 0xEB candidate seen while hunting
    logic [4:0]  byte_idx;
    logic [15:0] crc, crc_rx;
    logic [15:0] lgs_r, hit_r, eff_r;
    logic [23:0] busy_r;
    logic        rsv_nz;
    logic [9:0]  tmo_cnt;

    logic sync_hit, last_byte, tmo_hit, crc_bad, accept;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, c} + {7'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign sync_hit  = (state == HUNT) && byte_vld && have_eb && (fifo_data_in == 8'h90);
    assign last_byte = (state == COLLECT) && byte_vld && (byte_idx == 5'd19);
    assign tmo_hit   = (state == COLLECT) && !byte_vld && fifo_empty_in &&
                       (tmo_cnt == 10'(TIMEOUT_CYC - 1));
    assign crc_bad   = (crc != crc_rx);
    assign accept    = (state == OUT) && pkt_vld_out && pkt_rdy_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        fifo_rd_out = 1'b0;
        unique case (state)
            HUNT: begin
                fifo_rd_out = run && !fifo_empty_in;
                if (sync_hit) state_nxt = COLLECT;
            end
            COLLECT: begin
                // byte 19 is in flight once byte 18 has been sampled; stop there
                fifo_rd_out = run && !fifo_empty_in && !(byte_vld && byte_idx == 5'd19);
                if (last_byte)    state_nxt = CHECK;
                else if (tmo_hit) state_nxt = HUNT;
            end
            CHECK: begin
                state_nxt = (crc_bad || rsv_nz) ? HUNT : OUT;
            end
            OUT: begin
                if (accept) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            run               <= 1'b0;
            byte_vld          <= 1'b0;
            have_eb           <= 1'b0;
            byte_idx          <= 5'd0;
            crc               <= 16'hFFFF;
            crc_rx            <= 16'd0;
            lgs_r             <= 16'd0;
            hit_r             <= 16'd0;
            eff_r             <= 16'd0;
            busy_r            <= 24'd0;
            rsv_nz            <= 1'b0;
            tmo_cnt           <= 10'd0;
            pkt_vld_out       <= 1'b0;
            logic_grp_sel_out <= 16'd0;
            hit_sig_stus_out  <= 16'd0;
            eff_trg_cnt_out   <= 16'd0;
            trg_busy_time_out <= 24'd0;
            pkt_ok_cnt_out    <= 16'd0;
            crc_err_cnt_out   <= 8'd0;
            fmt_err_cnt_out   <= 8'd0;
            sync_drop_cnt_out <= 8'd0;
            timeout_cnt_out   <= 8'd0;
        end else begin
            run      <= 1'b1;
            byte_vld <= fifo_rd_out;
            unique case (state)
                HUNT: begin
                    crc     <= 16'hFFFF;
                    rsv_nz  <= 1'b0;
                    tmo_cnt <= 10'd0;
                    if (byte_vld) begin
                        if (have_eb) begin
                            if (fifo_data_in == 8'h90) begin
                                have_eb  <= 1'b0;
                                byte_idx <= 5'd2;
                            end else if (fifo_data_in == 8'hEB) begin
                                // older 0xEB dropped, newer one stays the candidate
                                sync_drop_cnt_out <= sat_add(sync_drop_cnt_out, 2'd1);
                            end else begin
                                // orphan 0xEB plus this byte
                                have_eb           <= 1'b0;
                                sync_drop_cnt_out <= sat_add(sync_drop_cnt_out, 2'd2);
                            end
                        end else if (fifo_data_in == 8'hEB) begin
                            have_eb <= 1'b1;
                        end else begin
                            sync_drop_cnt_out <= sat_add(sync_drop_cnt_out, 2'd1);
                        end
                    end
                end
                COLLECT: begin
                    if (byte_vld) begin
                        tmo_cnt  <= 10'd0;
                        byte_idx <= byte_idx + 5'd1;
                        if (byte_idx <= 5'd17) crc <= crc_byte(crc, fifo_data_in);
                        case (byte_idx)
                            5'd2, 5'd3, 5'd8, 5'd9, 5'd15, 5'd16, 5'd17:
                                if (fifo_data_in != 8'd0) rsv_nz <= 1'b1;
                            5'd4:  lgs_r[15:8]   <= fifo_data_in;
                            5'd5:  lgs_r[7:0]    <= fifo_data_in;
                            5'd6:  hit_r[15:8]   <= fifo_data_in;
                            5'd7:  hit_r[7:0]    <= fifo_data_in;
                            5'd10: eff_r[15:8]   <= fifo_data_in;
                            5'd11: eff_r[7:0]    <= fifo_data_in;
                            5'd12: busy_r[23:16] <= fifo_data_in;
                            5'd13: busy_r[15:8]  <= fifo_data_in;
                            5'd14: busy_r[7:0]   <= fifo_data_in;
                            5'd18: crc_rx[15:8]  <= fifo_data_in;
                            5'd19: crc_rx[7:0]   <= fifo_data_in;
                            default: ;
                        endcase
                    end else if (fifo_empty_in) begin
                        if (tmo_hit) timeout_cnt_out <= sat_add(timeout_cnt_out, 2'd1);
                        else         tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                CHECK: begin
                    if (crc_bad) begin
                        crc_err_cnt_out <= sat_add(crc_err_cnt_out, 2'd1);
                    end else if (rsv_nz) begin
                        fmt_err_cnt_out <= sat_add(fmt_err_cnt_out, 2'd1);
                    end else begin
                        logic_grp_sel_out <= lgs_r;
                        hit_sig_stus_out  <= hit_r;
                        eff_trg_cnt_out   <= eff_r;
                        trg_busy_time_out <= busy_r;
                        pkt_vld_out       <= 1'b1;
                    end
                end
                OUT: begin
                    if (accept) begin
                        pkt_vld_out    <= 1'b0;
                        pkt_ok_cnt_out <= pkt_ok_cnt_out + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trg_sci_pkt_reader.sv
`timescale 1ns/1ps
module tb_trg_sci_pkt_reader;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        fifo_empty_in;
    logic [7:0]  fifo_data_in = 8'd0;
    logic        fifo_rd_out;
    logic        pkt_vld_out;
    logic        pkt_rdy_in;
    logic [15:0] logic_grp_sel_out, hit_sig_stus_out, eff_trg_cnt_out;
    logic [23:0] trg_busy_time_out;
    logic [15:0] pkt_ok_cnt_out;
    logic [7:0]  crc_err_cnt_out, fmt_err_cnt_out, sync_drop_cnt_out, timeout_cnt_out;

    trg_sci_pkt_reader #(.TIMEOUT_CYC(1023)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .fifo_empty_in(fifo_empty_in), .fifo_data_in(fifo_data_in), .fifo_rd_out(fifo_rd_out),
        .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in),
        .logic_grp_sel_out(logic_grp_sel_out), .hit_sig_stus_out(hit_sig_stus_out),
        .eff_trg_cnt_out(eff_trg_cnt_out), .trg_busy_time_out(trg_busy_time_out),
        .pkt_ok_cnt_out(pkt_ok_cnt_out), .crc_err_cnt_out(crc_err_cnt_out),
        .fmt_err_cnt_out(fmt_err_cnt_out), .sync_drop_cnt_out(sync_drop_cnt_out),
        .timeout_cnt_out(timeout_cnt_out)
    );

    always #10 clk_in = ~clk_in;

    // FIFO model: standard read, dout valid the cycle after the read strobe
    logic [7:0] mem [0:1023];
    logic [9:0] wp = 10'd0;
    logic [9:0] rp = 10'd0;
    assign fifo_empty_in = (wp == rp);
    always @(posedge clk_in) begin
        if (fifo_rd_out && !fifo_empty_in) begin
            fifo_data_in <= mem[rp];
            rp <= rp + 10'd1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bit-serial CRC over the 16 covered bytes
    function automatic logic [15:0] crc_model(input logic [127:0] m);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 127; i >= 0; i--) begin
            fb = c[15] ^ m[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [7:0] pkt_b [0:19];

    // mode 0 good, 1 CRC byte19 ^ 1, 2 byte8 = 1 (CRC recomputed), 3 good with garbage prefix
    task automatic build_pkt(input logic [15:0] lgs, input logic [15:0] hit, input logic [15:0] eff,
                             input logic [23:0] busy, input int mode);
        logic [127:0] m;
        logic [15:0] c;
        for (int i = 0; i < 20; i++) pkt_b[i] = 8'd0;
        pkt_b[0] = 8'hEB; pkt_b[1] = 8'h90;
        pkt_b[4] = lgs[15:8];  pkt_b[5] = lgs[7:0];
        pkt_b[6] = hit[15:8];  pkt_b[7] = hit[7:0];
        pkt_b[10] = eff[15:8]; pkt_b[11] = eff[7:0];
        pkt_b[12] = busy[23:16]; pkt_b[13] = busy[15:8]; pkt_b[14] = busy[7:0];
        if (mode == 2) pkt_b[8] = 8'h01;
        for (int i = 0; i < 16; i++) m[127 - 8*i -: 8] = pkt_b[2 + i];
        c = crc_model(m);
        pkt_b[18] = c[15:8];
        pkt_b[19] = c[7:0];
        if (mode == 1) pkt_b[19] = pkt_b[19] ^ 8'h01;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 10'd1;
    endtask

    task automatic push_pkt(input int nbytes, input int mode);
        if (mode == 3) begin
            push_byte(8'h12);
            push_byte(8'hEB);
        end
        for (int i = 0; i < nbytes; i++) push_byte(pkt_b[i]);
    endtask

    // watch window: records first negedge with valid and the fields seen then
    logic        seen;
    int          first_j, nv;
    logic [15:0] c_lgs, c_hit, c_eff;
    logic [23:0] c_busy;

    task automatic watch(input int n);
        seen = 1'b0; first_j = -1; nv = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (pkt_vld_out) begin
                if (!seen) begin
                    first_j = j;
                    c_lgs = logic_grp_sel_out; c_hit = hit_sig_stus_out;
                    c_eff = eff_trg_cnt_out;   c_busy = trg_busy_time_out;
                end
                seen = 1'b1;
                nv++;
            end
        end
    endtask

    typedef struct {
        logic [15:0] lgs, hit, eff;
        logic [23:0] busy;
        int          mode;
        logic        exp_vld;
        logic [15:0] exp_ok;
        logic [7:0]  exp_crc, exp_fmt, exp_drop;
    } vec_t;

    vec_t vt [5];
    logic [15:0] ok_before;
    int          bad;
    int          waited;

    initial begin
        vt[0] = '{16'h8041, 16'h00A5, 16'h1234, 24'h0ABCDE, 1, 1'b0, 16'd1, 8'd1, 8'd0, 8'd0};
        vt[1] = '{16'hFFFF, 16'h0000, 16'h0001, 24'hFFFFFF, 0, 1'b1, 16'd2, 8'd1, 8'd0, 8'd0};
        vt[2] = '{16'h1357, 16'h2468, 16'h9ABC, 24'h123456, 3, 1'b1, 16'd3, 8'd1, 8'd0, 8'd2};
        vt[3] = '{16'h8041, 16'h00A5, 16'h1234, 24'h0ABCDE, 2, 1'b0, 16'd3, 8'd1, 8'd1, 8'd2};
        vt[4] = '{16'h0001, 16'h8000, 16'hFFFE, 24'h800001, 0, 1'b1, 16'd4, 8'd1, 8'd1, 8'd2};

        rst_in = 1'b1;
        pkt_rdy_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_vld", pkt_vld_out, 0);
        chk("rst_rd", fifo_rd_out, 0);
        chk("rst_fields", {logic_grp_sel_out, hit_sig_stus_out}, 0);
        chk("rst_cnts", {pkt_ok_cnt_out, crc_err_cnt_out, fmt_err_cnt_out}, 0);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // latency: first read in cycle t, valid exactly in cycle t+22 for one cycle
        build_pkt(16'h8041, 16'h00A5, 16'h1234, 24'h0ABCDE, 0);
        push_pkt(20, 0);
        watch(30);
        chk("lat_first", first_j, 22);
        chk("lat_width", nv, 1);
        chk("lat_lgs", c_lgs, 16'h8041);
        chk("lat_hit", c_hit, 16'h00A5);
        chk("lat_eff", c_eff, 16'h1234);
        chk("lat_busy", c_busy, 24'h0ABCDE);
        chk("lat_ok", pkt_ok_cnt_out, 1);
        chk("lat_hold_fields", logic_grp_sel_out, 16'h8041);

        for (int v = 0; v < 5; v++) begin
            build_pkt(vt[v].lgs, vt[v].hit, vt[v].eff, vt[v].busy, vt[v].mode);
            push_pkt(20, vt[v].mode);
            watch(45);
            chk($sformatf("vec%0d_vld", v), seen, vt[v].exp_vld);
            if (vt[v].exp_vld) begin
                chk($sformatf("vec%0d_lgs", v), c_lgs, vt[v].lgs);
                chk($sformatf("vec%0d_hit", v), c_hit, vt[v].hit);
                chk($sformatf("vec%0d_eff", v), c_eff, vt[v].eff);
                chk($sformatf("vec%0d_busy", v), c_busy, vt[v].busy);
            end
            chk($sformatf("vec%0d_ok", v), pkt_ok_cnt_out, vt[v].exp_ok);
            chk($sformatf("vec%0d_crc", v), crc_err_cnt_out, vt[v].exp_crc);
            chk($sformatf("vec%0d_fmt", v), fmt_err_cnt_out, vt[v].exp_fmt);
            chk($sformatf("vec%0d_drop", v), sync_drop_cnt_out, vt[v].exp_drop);
        end

        // starvation after byte 9
        build_pkt(16'hAAAA, 16'h5555, 16'h0F0F, 24'h010203, 0);
        push_pkt(10, 0);
        repeat (1000) @(negedge clk_in);
        chk("tmo_early", timeout_cnt_out, 0);
        repeat (60) @(negedge clk_in);
        chk("tmo_cnt", timeout_cnt_out, 1);
        chk("tmo_no_vld", pkt_vld_out, 0);
        build_pkt(16'hC0DE, 16'h0042, 16'h7777, 24'h00FFEE, 0);
        push_pkt(20, 0);
        watch(30);
        chk("tmo_next_vld", seen, 1);
        chk("tmo_next_lgs", c_lgs, 16'hC0DE);
        chk("tmo_next_busy", c_busy, 24'h00FFEE);
        chk("tmo_next_ok", pkt_ok_cnt_out, 5);

        // backpressure with a second packet queued
        pkt_rdy_in = 1'b0;
        ok_before = pkt_ok_cnt_out;
        build_pkt(16'h1111, 16'h2222, 16'h3333, 24'h444444, 0);
        push_pkt(20, 0);
        build_pkt(16'h5555, 16'h6666, 16'h7777, 24'h888888, 0);
        push_pkt(20, 0);
        waited = 0;
        while (!pkt_vld_out && waited < 40) begin
            @(negedge clk_in);
            waited++;
        end
        chk("bp_vld_up", pkt_vld_out, 1);
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk_in);
            if (!pkt_vld_out || fifo_rd_out || logic_grp_sel_out != 16'h1111 ||
                trg_busy_time_out != 24'h444444 || (wp - rp) != 10'd20) bad++;
        end
        chk("bp_stable_bad_cycles", bad, 0);
        chk("bp_ok_hold", pkt_ok_cnt_out, ok_before);
        pkt_rdy_in = 1'b1;
        watch(30);
        chk("bp_second_vld", seen, 1);
        chk("bp_second_lgs", c_lgs, 16'h5555);
        chk("bp_second_eff", c_eff, 16'h7777);
        chk("bp_ok", pkt_ok_cnt_out, ok_before + 16'd2);

        // reset in the middle of a packet
        build_pkt(16'h0BAD, 16'h0C0C, 16'h0D0D, 24'h0E0E0E, 0);
        push_pkt(20, 0);
        repeat (12) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("mrst_rd", fifo_rd_out, 0);
        chk("mrst_vld", pkt_vld_out, 0);
        chk("mrst_fields", {logic_grp_sel_out, eff_trg_cnt_out, trg_busy_time_out}, 0);
        chk("mrst_cnts", {pkt_ok_cnt_out, crc_err_cnt_out, fmt_err_cnt_out}, 0);
        chk("mrst_cnts2", {sync_drop_cnt_out, timeout_cnt_out}, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("mrst_rd_before_edge", fifo_rd_out, 0);
        @(posedge clk_in); #1;
        chk("mrst_rd_after_edge", fifo_rd_out, 1);
        @(negedge clk_in);
        watch(30);
        build_pkt(16'h8041, 16'h00A5, 16'h1234, 24'h0ABCDE, 0);
        push_pkt(20, 0);
        watch(30);
        chk("mrst_next_vld", seen, 1);
        chk("mrst_next_lgs", c_lgs, 16'h8041);
        chk("mrst_next_busy", c_busy, 24'h0ABCDE);
        chk("mrst_next_ok", pkt_ok_cnt_out, 1);
        chk("mrst_next_crc", crc_err_cnt_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
